sgf_addsub_arbiter: RTL and testbench

SGF_ADDSUB_ARBITER -- requirements
Module: sgf_addsub_arbiter

---
 rtl/sgf_addsub_arbiter_pkg.sv | 19 +
 rtl/sgf_addsub_arbiter_rr_arbiter2.sv | 33 +++
 rtl/sgf_addsub_arbiter.sv | 131 +++++++++++++
 tb/tb_sgf_addsub_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgf_addsub_arbiter_pkg.sv
// Shared definitions for the FPU add/sub significand path: datapath width,
// arbiter FSM encoding and small helpers used by the request arbiter.
package sgf_addsub_arbiter_pkg;

    localparam int SGF_SWR = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Grants are one-hot, so the requester id is simply the upper grant bit.
    function automatic logic grant_to_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/sgf_addsub_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On contention the requester that did not win
// last time is granted; last_grant only moves when a grant is consumed.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/sgf_addsub_arbiter.sv
// Shares one external significand adder between two requesters: arbitrates,
// issues one load to the adder, collects its registered result and returns it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a valid request; ready raised for the grantee
//   ST_ISSUE | add_load_o high, latched operands presented to the adder
//   ST_WAIT  | adder result registered; capture it into response regs
//   ST_RESP  | rsp_valid_o high until rsp_ready_i completes the handshake
module sgf_addsub_arbiter
    import sgf_addsub_arbiter_pkg::*;
#(
    parameter int SWR = SGF_SWR
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           req0_valid_i,
    output logic           req0_ready_o,
    input  logic           req0_op_i,
    input  logic [SWR-1:0] req0_a_i,
    input  logic [SWR-1:0] req0_b_i,

    input  logic           req1_valid_i,
    output logic           req1_ready_o,
    input  logic           req1_op_i,
    input  logic [SWR-1:0] req1_a_i,
    input  logic [SWR-1:0] req1_b_i,

    output logic           add_load_o,
    output logic           add_op_o,
    output logic [SWR-1:0] add_a_o,
    output logic [SWR-1:0] add_b_o,
    input  logic [SWR-1:0] add_result_i,
    input  logic           add_carry_i,

    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic           rsp_id_o,
    output logic [SWR-1:0] rsp_result_o,
    output logic           rsp_carry_o,

    output logic           busy_o
);

    arb_state_t     state_q;
    logic           id_q;
    logic [1:0]     req_valid;
    logic [1:0]     grant;
    logic           accept;
    logic           sel_id;
    logic           sel_op;
    logic [SWR-1:0] sel_a;
    logic [SWR-1:0] sel_b;

    assign req_valid = {req1_valid_i, req0_valid_i};

    rr_arbiter2 u_rr_arbiter2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .update (accept),
        .grant  (grant)
    );

    // Ready is combinational on valid; rst gates it so outputs read 0 in reset.
    assign accept       = rst && (state_q == ST_IDLE) && (|grant);
    assign req0_ready_o = accept && grant[0];
    assign req1_ready_o = accept && grant[1];

    assign sel_id = grant_to_id(grant);
    assign sel_op = sel_id ? req1_op_i : req0_op_i;
    assign sel_a  = sel_id ? req1_a_i  : req0_a_i;
    assign sel_b  = sel_id ? req1_b_i  : req0_b_i;

    // The add_* registers double as the operand latch and hold between issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            id_q         <= 1'b0;
            add_load_o   <= 1'b0;
            add_op_o     <= 1'b0;
            add_a_o      <= '0;
            add_b_o      <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
            rsp_result_o <= '0;
            rsp_carry_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q    <= ST_ISSUE;
                        id_q       <= sel_id;
                        add_load_o <= 1'b1;
                        add_op_o   <= sel_op;
                        add_a_o    <= sel_a;
                        add_b_o    <= sel_b;
                        busy_o     <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q    <= ST_WAIT;
                    add_load_o <= 1'b0;
                end
                ST_WAIT: begin
                    state_q      <= ST_RESP;
                    rsp_result_o <= add_result_i;
                    rsp_carry_o  <= add_carry_i;
                    rsp_id_o     <= id_q;
                    rsp_valid_o  <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    add_load_o  <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgf_addsub_arbiter.sv
// Bench for sgf_addsub_arbiter: registered adder model, response scoreboard,
// vector table plus contention, back-pressure and mid-flight reset sequences.
module tb_sgf_addsub_arbiter;

    localparam int SWR = 26;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic           req0_ready_o, req1_ready_o;
    logic           req0_op_i = 1'b0, req1_op_i = 1'b0;
    logic [SWR-1:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
    logic           add_load_o, add_op_o;
    logic [SWR-1:0] add_a_o, add_b_o;
    logic [SWR-1:0] add_result_i = '0;
    logic           add_carry_i = 1'b0;
    logic           rsp_valid_o, rsp_id_o, rsp_carry_o, busy_o;
    logic           rsp_ready_i = 1'b1;
    logic [SWR-1:0] rsp_result_o;

    sgf_addsub_arbiter #(.SWR(SWR)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_op_i    (req0_op_i),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_op_i    (req1_op_i),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .add_load_o   (add_load_o),
        .add_op_o     (add_op_o),
        .add_a_o      (add_a_o),
        .add_b_o      (add_b_o),
        .add_result_i (add_result_i),
        .add_carry_i  (add_carry_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_carry_o  (rsp_carry_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // External adder: {carry,sum} = A + (B ^ {SWR{op}}) + op, registered on load.
    always @(posedge clk) begin
        if (add_load_o)
            {add_carry_i, add_result_i} <= {1'b0, add_a_o}
                                         + {1'b0, add_b_o ^ {SWR{add_op_o}}}
                                         + {{SWR{1'b0}}, add_op_o};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic           id;
        logic           op;
        logic [SWR-1:0] a;
        logic [SWR-1:0] b;
        logic [SWR-1:0] res;
        logic           carry;
    } vec_t;

    typedef struct {
        logic           id;
        logic [SWR-1:0] res;
        logic           carry;
        int             acc;
    } sb_t;

    vec_t tbl[8];
    sb_t  sbq[$];
    int   total = 0;
    int   bad   = 0;
    bit   both_rdy_seen = 0;
    bit   double_load   = 0;
    bit   prev_load     = 0;
    bit   prev_rv       = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [SWR:0] ref_op(input logic op, input logic [SWR-1:0] a,
                                            input logic [SWR-1:0] b);
        logic [SWR-1:0] d;
        if (op) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [127:0] all_outs();
        return {req0_ready_o, req1_ready_o, add_load_o, add_op_o, add_a_o, add_b_o,
                rsp_valid_o, rsp_id_o, rsp_result_o, rsp_carry_o, busy_o};
    endfunction

    // Response monitor: latency on first rsp_valid, contents on handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (req0_ready_o && req1_ready_o) both_rdy_seen = 1;
            if (add_load_o && prev_load) double_load = 1;
            prev_load = add_load_o;
            if (rsp_valid_o && !prev_rv && sbq.size() > 0)
                chk("rsp_latency", 128'(cyc - sbq[0].acc), 128'd3);
            prev_rv = rsp_valid_o;
            if (rsp_valid_o && rsp_ready_i) begin
                if (sbq.size() == 0) begin
                    chk("spurious_rsp", 128'd1, 128'd0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("rsp_id", 128'(rsp_id_o), 128'(e.id));
                    chk("rsp_result", 128'(rsp_result_o), 128'(e.res));
                    chk("rsp_carry", 128'(rsp_carry_o), 128'(e.carry));
                end
            end
        end else begin
            prev_load = 0;
            prev_rv   = 0;
        end
    end

    task automatic drive(input logic id, input logic v, input logic op,
                         input logic [SWR-1:0] a, input logic [SWR-1:0] b);
        if (id) begin
            req1_valid_i = v; req1_op_i = op; req1_a_i = a; req1_b_i = b;
        end else begin
            req0_valid_i = v; req0_op_i = op; req0_a_i = a; req0_b_i = b;
        end
    endtask

    task automatic issue(input vec_t v, input bit push);
        bit got = 0;
        @(posedge clk); #1;
        drive(v.id, 1'b1, v.op, v.a, v.b);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (v.id ? req1_ready_o : req0_ready_o) begin
                got = 1;
                if (push) sbq.push_back('{v.id, v.res, v.carry, cyc});
                break;
            end
        end
        chk("accept", 128'(got), 128'd1);
        @(posedge clk); #1;
        if (v.id) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !rsp_valid_o) begin done = 1; break; end
        end
        chk("drain", 128'(done), 128'd1);
    endtask

    initial begin
        vec_t  v;
        logic [SWR:0] r;
        int    order[2];
        int    nserved;
        bit    r0, r1, seen;

        tbl[0] = '{1'b0, 1'b0, 26'h0000010, 26'h0000003, 26'h0000013, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 26'h0000010, 26'h0000003, 26'h000000D, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 26'h3FFFFFF, 26'h0000001, 26'h0000000, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 26'h0000003, 26'h0000010, 26'h3FFFFF3, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 26'h0000005, 26'h0000005, 26'h0000000, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 26'h2000000, 26'h2000000, 26'h0000000, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 26'h1234567, 26'h0FEDCBA, 26'h2222221, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 26'h0000000, 26'h3FFFFFF, 26'h0000001, 1'b0};

        // Both requesters valid while in reset: every output must read 0.
        drive(1'b0, 1'b1, tbl[0].op, tbl[0].a, tbl[0].b);
        drive(1'b1, 1'b1, tbl[1].op, tbl[1].a, tbl[1].b);
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Contention out of reset: req0 first, then req1.
        nserved = 0;
        for (int n = 0; n < 60 && nserved < 2; n++) begin
            @(negedge clk);
            r0 = req0_ready_o;
            r1 = req1_ready_o;
            if (r0) begin
                sbq.push_back('{tbl[0].id, tbl[0].res, tbl[0].carry, cyc});
                order[nserved] = 0;
                nserved++;
            end
            if (r1 && nserved < 2) begin
                sbq.push_back('{tbl[1].id, tbl[1].res, tbl[1].carry, cyc});
                order[nserved] = 1;
                nserved++;
            end
            if (r0 || r1) begin
                @(posedge clk); #1;
                if (r0) req0_valid_i = 1'b0;
                if (r1) req1_valid_i = 1'b0;
            end
        end
        chk("contention_served", 128'(nserved), 128'd2);
        chk("contention_first", 128'(order[0]), 128'd0);
        chk("contention_second", 128'(order[1]), 128'd1);
        drain();

        for (int i = 2; i < 8; i++) begin
            issue(tbl[i], 1'b1);
            drain();
        end

        for (int i = 0; i < 4; i++) begin
            v.id  = 1'($urandom_range(0, 1));
            v.op  = 1'($urandom_range(0, 1));
            v.a   = SWR'($urandom);
            v.b   = SWR'($urandom);
            r     = ref_op(v.op, v.a, v.b);
            v.res = r[SWR-1:0];
            v.carry = r[SWR];
            issue(v, 1'b1);
            drain();
        end

        // Back-pressure: response held 5 cycles while req1 waits.
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        v = '{1'b0, 1'b0, 26'h0000155, 26'h00002AA, 26'h00003FF, 1'b0};
        issue(v, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 26'h0000100, 26'h0000001);
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid_o) begin seen = 1; break; end
        end
        chk("stall_rsp_seen", 128'(seen), 128'd1);
        for (int n = 0; n < 5; n++) begin
            chk("stall_valid", 128'(rsp_valid_o), 128'd1);
            chk("stall_result", 128'(rsp_result_o), 128'h3FF);
            chk("stall_carry_id", 128'({rsp_carry_o, rsp_id_o}), 128'd0);
            chk("stall_ready", 128'({req0_ready_o, req1_ready_o}), 128'd0);
            @(negedge clk);
        end
        chk("stall_add_a_hold", 128'(add_a_o), 128'h155);
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        issue('{1'b1, 1'b1, 26'h0000100, 26'h0000001, 26'h00000FF, 1'b1}, 1'b1);
        drain();

        // Reset pulsed in WAIT: outputs clear at once, no response follows.
        issue('{1'b0, 1'b0, 26'h0000777, 26'h0000001, 26'h0000778, 1'b0}, 1'b0);
        @(posedge clk); #1;
        chk("wait_busy", 128'(busy_o), 128'd1);
        rst = 1'b0;
        #1;
        chk("reset_in_wait", all_outs(), 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rsp_valid_o || busy_o) seen = 1;
        end
        chk("no_rsp_after_reset", 128'(seen), 128'd0);
        issue('{1'b1, 1'b0, 26'h0000020, 26'h0000022, 26'h0000042, 1'b0}, 1'b1);
        drain();

        chk("both_ready_never", 128'(both_rdy_seen), 128'd0);
        chk("load_one_cycle", 128'(double_load), 128'd0);
        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
